pipe4_sync_tx: RTL and testbench



---
 rtl/pipe4_sync_tx.sv | 126 ++++++++++++
 tb/tb_pipe4_sync_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe4_sync_tx.sv
// pipe4_sync_tx: FIFO-buffered valid/ready to 4-phase 1-of-4 QDI transmitter with synchronised acks.
module pipe4_sync_tx #(
    parameter int DW     = 32,
    parameter int SCN    = DW / 2,
    parameter int DEPTH  = 4,
    parameter int SYNC   = 2,
    parameter int EOF_EN = 1,
    parameter int TMO    = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DW-1:0]              din,
    input  logic                       din_eof,
    input  logic                       din_vld,
    output logic                       din_rdy,
    output logic [SCN-1:0]             o0,
    output logic [SCN-1:0]             o1,
    output logic [SCN-1:0]             o2,
    output logic [SCN-1:0]             o3,
    output logic                       o4,
    input  logic [SCN-1:0]             oa,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TMO + 2);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;

    logic [DW:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rdy_q, rdy_d;
    // Top bit of each stage is a fill marker so cleared stages never look like a real all-low ack.
    logic [SCN:0]    sync_q [SYNC];
    logic [SCN-1:0]  ack_s;
    logic            all_hi, all_lo;
    state_t          st_q, st_d;
    logic [SCN-1:0]  o0_q, o0_d, o1_q, o1_d, o2_q, o2_d, o3_q, o3_d;
    logic [SCN-1:0]  enc0, enc1, enc2, enc3;
    logic            o4_q, o4_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            err_q, err_d;
    logic            push, pop, leave;
    logic [DW:0]     head;

    always_comb begin
        push   = din_vld && rdy_q;
        ack_s  = sync_q[SYNC-1][SCN-1:0];
        all_hi = sync_q[SYNC-1][SCN] && (&ack_s);
        all_lo = sync_q[SYNC-1][SCN] && !(|ack_s);
        pop    = (st_q == S_IDLE) && (cnt_q != '0) && all_lo;
        leave  = (st_q == S_DATA) && all_hi;
        head   = mem_q[rd_q];
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        rdy_d  = cnt_d != CW'(DEPTH);
        enc0   = '0;
        enc1   = '0;
        enc2   = '0;
        enc3   = '0;
        for (int k = 0; k < SCN; k++) begin
            enc0[k] = head[2*k +: 2] == 2'd0;
            enc1[k] = head[2*k +: 2] == 2'd1;
            enc2[k] = head[2*k +: 2] == 2'd2;
            enc3[k] = head[2*k +: 2] == 2'd3;
        end
        st_d  = pop ? S_DATA : leave ? S_NULL : (st_q == S_NULL && all_lo) ? S_IDLE : st_q;
        o0_d  = pop ? enc0 : leave ? '0 : o0_q;
        o1_d  = pop ? enc1 : leave ? '0 : o1_q;
        o2_d  = pop ? enc2 : leave ? '0 : o2_q;
        o3_d  = pop ? enc3 : leave ? '0 : o3_q;
        o4_d  = pop ? (EOF_EN != 0) && head[DW] : leave ? 1'b0 : o4_q;
        tmr_d = (st_d != st_q) ? '0 :
                (st_q != S_IDLE && tmr_q != TW'(TMO)) ? tmr_q + 1'b1 : tmr_q;
        err_d = err_q || ((TMO != 0) && (tmr_d == TW'(TMO)));
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {din_eof, din};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
            st_q  <= S_IDLE;
            o0_q  <= '0;
            o1_q  <= '0;
            o2_q  <= '0;
            o3_q  <= '0;
            o4_q  <= 1'b0;
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            sync_q[0] <= {1'b1, oa};
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
            st_q      <= st_d;
            o0_q      <= o0_d;
            o1_q      <= o1_d;
            o2_q      <= o2_d;
            o3_q      <= o3_d;
            o4_q      <= o4_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
        end
    end

    assign din_rdy = rdy_q;
    assign o0      = o0_q;
    assign o1      = o1_q;
    assign o2      = o2_q;
    assign o3      = o3_q;
    assign o4      = o4_q;
    assign cnt     = cnt_q;
    assign err     = err_q;
endmodule

// File: tb/tb_pipe4_sync_tx.sv
// tb_pipe4_sync_tx: scoreboard bench for pipe4_sync_tx (DW=8, DEPTH=4, SYNC=2, TMO=16).
module tb_pipe4_sync_tx;
    localparam int DW = 8, SCN = 4, DEPTH = 4, SYNC = 2, TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  din = '0;
    logic           din_eof = 1'b0;
    logic           din_vld = 1'b0;
    logic           din_rdy;
    logic [SCN-1:0] o0, o1, o2, o3;
    logic           o4;
    logic [SCN-1:0] oa = '0;
    logic [2:0]     cnt;
    logic           err;

    int          nvec = 0, nbad = 0, cyc = 0;
    logic [DW:0] sb [$];
    int          starts [$];
    bit          auto_ack = 1'b0, prev_vld = 1'b0;

    always #5 clk = ~clk;

    pipe4_sync_tx #(.DW(DW), .SCN(SCN), .DEPTH(DEPTH), .SYNC(SYNC), .EOF_EN(1), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_eof(din_eof), .din_vld(din_vld),
        .din_rdy(din_rdy), .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .oa(oa),
        .cnt(cnt), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at negedge, decode new words against the scoreboard, run the ack model.
    task automatic tick();
        logic [DW-1:0] w;
        logic          bad;
        logic          on;
        @(negedge clk);
        cyc++;
        on = |{o0, o1, o2, o3};
        if (on && !prev_vld) begin
            w   = '0;
            bad = 1'b0;
            for (int k = 0; k < SCN; k++) begin
                if ($countones({o0[k], o1[k], o2[k], o3[k]}) != 1) bad = 1'b1;
                w[2*k +: 2] = o1[k] ? 2'd1 : o2[k] ? 2'd2 : o3[k] ? 2'd3 : 2'd0;
            end
            check("onehot", 32'(bad), 0);
            if (sb.size() == 0) check("sb_unexpected_word", 32'({o4, w}), 32'h1ff);
            else check("word", 32'({o4, w}), 32'(sb.pop_front()));
            starts.push_back(cyc);
        end
        prev_vld = on;
        if (auto_ack) oa = on ? '1 : '0;
    endtask

    task automatic push(input logic [DW-1:0] w, input logic e);
        int n = 0;
        din = w;
        din_eof = e;
        din_vld = 1'b1;
        while (!din_rdy && n < 50) begin
            tick();
            n++;
        end
        if (din_rdy) begin
            sb.push_back({e, w});
            tick();
        end else check("push_timeout", 32'(din_rdy), 1);
        din_vld = 1'b0;
    endtask

    task automatic wait_rails(input bit on, input int lim);
        int n = 0;
        while ((|{o0, o1, o2, o3}) != on && n < lim) begin
            tick();
            n++;
        end
        check(on ? "rails_on" : "rails_off", 32'(|{o0, o1, o2, o3}), 32'(on));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        auto_ack = 1'b1;
        while ((sb.size() != 0 || (|{o0, o1, o2, o3})) && n < 100) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 0);
        auto_ack = 1'b0;
        oa = '0;
        repeat (SYNC + 2) tick();
    endtask

    initial begin
        logic [4*SCN-1:0] r;
        bit               ok;
        int               n;

        repeat (3) tick();
        check("rst_rdy", 32'(din_rdy), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_rails", 32'({o4, o3, o2, o1, o0}), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick();
        check("rdy_after_rst", 32'(din_rdy), 1);

        push(8'hE4, 1'b1);
        wait_rails(1'b1, 10);
        check("enc_o0", 32'(o0), 32'h1);
        check("enc_o1", 32'(o1), 32'h2);
        check("enc_o2", 32'(o2), 32'h4);
        check("enc_o3", 32'(o3), 32'h8);
        check("enc_o4", 32'(o4), 1);
        oa = '1;
        repeat (SYNC) tick();
        check("data_hold", 32'(o0), 32'h1);
        tick();
        check("null_timing", 32'({o4, o3, o2, o1, o0}), 0);
        oa = '0;
        repeat (SYNC + 2) tick();

        starts.delete();
        auto_ack = 1'b1;
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        push(8'h1B, 1'b0);
        drain("b2b_drain");
        check("b2b_starts", starts.size(), 3);
        if (starts.size() == 3) begin
            check("b2b_gap0", starts[1] - starts[0], 2*SYNC + 3);
            check("b2b_gap1", starts[2] - starts[1], 2*SYNC + 3);
        end

        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        push(8'h44, 1'b0);
        push(8'h55, 1'b0);
        check("bp_cnt_full", 32'(cnt), DEPTH);
        check("bp_rdy_full", 32'(din_rdy), 0);
        din = 8'h66;
        din_vld = 1'b1;
        repeat (5) tick();
        check("bp_stall_cnt", 32'(cnt), DEPTH);
        din_vld = 1'b0;
        oa = '1;
        wait_rails(1'b0, 10);
        oa = '0;
        n = 0;
        while (cnt != 3'(DEPTH - 1) && n < 10) begin
            tick();
            n++;
        end
        check("bp_cnt_free", 32'(cnt), DEPTH - 1);
        check("bp_rdy_free", 32'(din_rdy), 1);
        repeat (3) tick();
        check("bp_one_slot", 32'(cnt), DEPTH - 1);
        push(8'h66, 1'b0);
        check("bp_refill", 32'(cnt), DEPTH);
        drain("bp_drain");

        push(8'h9C, 1'b0);
        wait_rails(1'b1, 10);
        r = {o3, o2, o1, o0};
        oa = 4'b0111;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if ({o3, o2, o1, o0} !== r) ok = 1'b0;
        end
        check("partial_hold", 32'(ok), 1);
        oa = '1;
        repeat (SYNC) tick();
        check("partial_data", 32'({o3, o2, o1, o0}), 32'(r));
        tick();
        check("partial_null", 32'({o4, o3, o2, o1, o0}), 0);
        oa = '0;
        repeat (SYNC + 2) tick();

        push(8'h5A, 1'b1);
        wait_rails(1'b1, 10);
        oa = '1;
        rst_n = 1'b0;
        tick();
        check("mid_rst_rails", 32'({o4, o3, o2, o1, o0}), 0);
        check("mid_rst_cnt", 32'(cnt), 0);
        check("mid_rst_err", 32'(err), 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        push(8'hC3, 1'b0);
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (|{o0, o1, o2, o3}) ok = 1'b0;
        end
        check("stale_ack_hold", 32'(ok), 1);
        oa = '0;
        wait_rails(1'b1, 10);
        oa = '1;
        wait_rails(1'b0, 10);
        oa = '0;
        repeat (SYNC + 2) tick();
        check("post_rst_sb", sb.size(), 0);

        check("wd_pre", 32'(err), 0);
        push(8'h77, 1'b1);
        wait_rails(1'b1, 10);
        repeat (TMO - 1) tick();
        check("wd_early", 32'(err), 0);
        tick();
        check("wd_set", 32'(err), 1);
        oa = '1;
        wait_rails(1'b0, 10);
        oa = '0;
        repeat (SYNC + 2) tick();
        check("wd_sticky", 32'(err), 1);
        check("wd_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
